// File: rtl/trng_seed_collector.sv
// TRNG requester that assembles ChaCha20 key/nonce seed material and owns the block counter.
// Optional TRNG_REPCHECK_EN adds a repetition-count health test on accepted words.
module trng_seed_collector #(
    parameter int unsigned WORD_W         = 32,
    parameter int unsigned KEY_WORDS      = 8,
    parameter int unsigned NONCE_WORDS    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] COUNTER_INIT   = 32'h0000_0001
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            collect,
    input  logic                            advance,
    output logic                            busy,
    output logic                            valid,
    output logic                            error,
    output logic                            trng_request,
    input  logic                            trng_ready,
    input  logic [WORD_W-1:0]               trng_data,
    output logic [WORD_W*KEY_WORDS-1:0]     key,
    output logic [WORD_W*NONCE_WORDS-1:0]   nonce,
    output logic [31:0]                     counter
);

    localparam int unsigned TOTAL_WORDS = KEY_WORDS + NONCE_WORDS;
    localparam int unsigned IDX_W       = $clog2(TOTAL_WORDS + 1);
    localparam int unsigned TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned KEY_W       = WORD_W * KEY_WORDS;
    localparam int unsigned NONCE_W     = WORD_W * NONCE_WORDS;

    typedef enum logic [1:0] {IDLE, REQ, READY, ERROR} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [KEY_W-1:0]     key_d;
    logic [NONCE_W-1:0]   nonce_d;
    logic [31:0]          cnt_d;
    logic                 busy_d, valid_d, error_d, req_d;
    logic                 accept;

`ifdef TRNG_REPCHECK_EN
    localparam int unsigned REP_MAX = 4;
    logic [WORD_W-1:0]    prev_q, prev_d;
    logic                 pvld_q, pvld_d;
    logic [2:0]           rep_q, rep_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        key_d   = key;
        nonce_d = nonce;
        cnt_d   = counter;
        accept  = 1'b0;
`ifdef TRNG_REPCHECK_EN
        prev_d  = prev_q;
        pvld_d  = pvld_q;
        rep_d   = rep_q;
`endif
        case (state_q)
            IDLE, READY, ERROR: begin
                if (collect) begin
                    state_d = REQ;
                    idx_d   = '0;
                    tmo_d   = '0;
`ifdef TRNG_REPCHECK_EN
                    pvld_d  = 1'b0;
                    rep_d   = '0;
`endif
                end else if (state_q == READY && advance) begin
                    if (counter == 32'hFFFF_FFFF) begin
                        cnt_d   = 32'h0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = counter + 32'd1;
                    end
                end
            end
            REQ: begin
                if (trng_ready) begin
                    accept = 1'b1;
`ifdef TRNG_REPCHECK_EN
                    // Repeated word: drop it and keep requesting
                    if (pvld_q && trng_data == prev_q) begin
                        accept = 1'b0;
                        tmo_d  = '0;
                        if (rep_q == 3'(REP_MAX - 1)) state_d = ERROR;
                        else                          rep_d   = rep_q + 3'd1;
                    end
`endif
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERROR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end

                if (accept) begin
                    idx_d = idx_q + IDX_W'(1);
                    tmo_d = '0;
                    for (int i = 0; i < KEY_WORDS; i++)
                        if (idx_q == IDX_W'(i)) key_d[WORD_W*i +: WORD_W] = trng_data;
                    for (int j = 0; j < NONCE_WORDS; j++)
                        if (idx_q == IDX_W'(KEY_WORDS + j)) nonce_d[WORD_W*j +: WORD_W] = trng_data;
`ifdef TRNG_REPCHECK_EN
                    prev_d = trng_data;
                    pvld_d = 1'b1;
                    rep_d  = '0;
`endif
                    if (idx_q == IDX_W'(TOTAL_WORDS - 1)) begin
                        state_d = READY;
                        cnt_d   = COUNTER_INIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so status flags are registered
    always_comb begin
        busy_d  = (state_d == REQ);
        req_d   = (state_d == REQ);
        valid_d = (state_d == READY);
        error_d = (state_d == ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            tmo_q        <= '0;
            key          <= '0;
            nonce        <= '0;
            counter      <= COUNTER_INIT;
            busy         <= 1'b0;
            valid        <= 1'b0;
            error        <= 1'b0;
            trng_request <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            key          <= key_d;
            nonce        <= nonce_d;
            counter      <= cnt_d;
            busy         <= busy_d;
            valid        <= valid_d;
            error        <= error_d;
            trng_request <= req_d;
        end
    end

`ifdef TRNG_REPCHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            pvld_q <= 1'b0;
            rep_q  <= '0;
        end else begin
            prev_q <= prev_d;
            pvld_q <= pvld_d;
            rep_q  <= rep_d;
        end
    end
`endif

endmodule

// File: doc/trng_seed_collector.md
Name: trng_seed_collector

Overview:
- Requester side of the TRNG handshake (trng_request / ready / random_number).
- Pulls 32-bit random words from the TRNG and assembles a 256-bit key and a 96-bit nonce. Maintains the 32-bit block counter.
- Presents all three as stable, validated seed material to the ChaCha20 core in the top level. This replaces the fixed key/nonce/counter constants.

Parameters:
- WORD_W, 32, width of one TRNG word.
- KEY_WORDS, 8, number of words forming the key.
- NONCE_WORDS, 3, number of words forming the nonce.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for trng_ready on one word before error.
- COUNTER_INIT, 32'h00000001, counter value loaded at reset and on each completed collection.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  synchronous reset, active-high.
- collect  in  1  single-cycle pulse that starts a new key/nonce collection.
- advance  in  1  single-cycle pulse that increments the counter after the core has consumed a block.
- busy  out  1  high while a collection is in progress.
- valid  out  1  high while key, nonce and counter are usable.
- error  out  1  sticky flag for a TRNG timeout (or health failure, see Optional Feature).
- trng_request  out  1  request for the next TRNG word.
- trng_ready  in  1  TRNG word available this cycle.
- trng_data  in  WORD_W  random word from the TRNG; sampled only when trng_request && trng_ready.
- key  out  32*KEY_WORDS  assembled key.
- nonce  out  32*NONCE_WORDS  assembled nonce.
- counter  out  32  current block counter.

Behaviour:
- Reset (rst=1 at a clock edge) puts every output to its reset value:
  - busy=0, valid=0, error=0, trng_request=0.
  - key=0, nonce=0, counter=COUNTER_INIT.
  - FSM=IDLE, word index=0, timeout count=0.
- Reset mid-collection aborts the collection immediately and drops trng_request on the following cycle.
- FSM states: IDLE, REQ, READY, ERROR.
- IDLE / READY / ERROR + collect:
  - Move to REQ, clear valid and error, set index=0 and timeout count=0.
  - key and nonce keep their old values until overwritten.
- REQ:
  - busy=1 and trng_request=1 throughout.
  - Each cycle with trng_ready=1 accepts one word.
  - Words 0..KEY_WORDS-1 go to key[32*i +: 32], so word 0 lands in key[31:0].
  - Words KEY_WORDS..KEY_WORDS+NONCE_WORDS-1 go to nonce[32*j +: 32].
  - Accepting a word increments the index and clears the timeout count.
  - On accepting the last word: load counter=COUNTER_INIT, go to READY, and drop trng_request on the next cycle.
- Timeout: in REQ, each cycle with trng_ready=0 increments the timeout count. When it reaches TIMEOUT_CYCLES, go to ERROR.
- ERROR: error=1, busy=0, valid=0, trng_request=0. Only collect or rst leaves this state.
- READY:
  - valid=1, busy=0.
  - advance increments counter by 1 (mod 2^32).
  - If counter==32'hFFFFFFFF when advance arrives, counter wraps to 0, valid drops to 0, and the FSM goes to IDLE. This prevents keystream reuse; a new collect is required.
- Latency: with trng_ready tied high, collect sampled at edge 0 gives busy=1 after edge 0, 11 words accepted on edges 1..11, and valid=1 after edge 11.
- Ignored inputs:
  - collect while in REQ is ignored.
  - advance is ignored in every state except READY.
- Simultaneous collect and advance in READY: collect wins and the counter is not incremented.
- key, nonce and counter are registered outputs and change only on the events above.

Optional Feature:
- Macro TRNG_REPCHECK_EN enables a repetition-count health test.
- With TRNG_REPCHECK_EN:
  - A word equal to the previously accepted word (within the same collection) is discarded. The index does not advance, trng_request stays high, and a repeat counter increments.
  - 4 consecutive discards force the ERROR state.
  - The repeat counter clears on any accepted word and on collect.
- Without TRNG_REPCHECK_EN: every handshaken word is accepted and there is no previous-word register.

Test Plan:
- rst, collect, trng_ready=1, trng_data=32'h1000_0000+n for word n -> valid=1 after 11 transfers. key[31:0]=32'h10000000, key[255:224]=32'h10000007, nonce[95:64]=32'h1000000A, counter=1.
- trng_ready toggled 1,0,0,1 during collection -> only ready cycles advance the index. valid is reached after 11 accepted words; trng_request stays high throughout REQ.
- trng_ready held 0 after collect -> error=1 and trng_request=0 after exactly TIMEOUT_CYCLES cycles. A following collect clears error and restarts.
- In READY, three advance pulses -> counter=4. Force counter=32'hFFFFFFFF and pulse advance -> counter=0, valid=0, FSM in IDLE.
- rst asserted after 5 words accepted -> all outputs at reset values on the next cycle. A subsequent collect completes a normal 11-word collection.
- With TRNG_REPCHECK_EN, feed word 32'hDEADBEEF five times in a row -> the first is accepted and the next four are discarded, then error=1. Without the macro, the same stimulus yields five accepted words.
